ftrans_rot: RTL and testbench

- Parametrised trivial-twiddle rotation stage for the radix-2^2 SDF FFT/IFFT datapath. Sits between the butterfly-I and butterfly-II of a stage pair.
- Tracks the sample index internally with a frame counter driven by a start-of-frame strobe.
- Per-frame direction: multiply by -j in quadrant 3 for FFT, or by +j for IFFT. All other quadrants pass through.
- Registered two-stage pipeline with valid, start-of-frame and end-of-frame sideband, and optional saturating negation.

---
 rtl/ftrans_rot_pkg.sv | 33 +++
 rtl/ftrans_neg_sat.sv | 24 ++
 rtl/ftrans_rot.sv | 144 ++++++++++++++
 tb/tb_ftrans_rot.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ftrans_rot_pkg.sv
// Shared definitions for the ftrans_rot rotation stage: mode encoding,
// complex-sample field helpers and the simulation delay constant.
package ftrans_rot_pkg;

  typedef enum logic {
    MODE_FFT  = 1'b0,
    MODE_IFFT = 1'b1
  } mode_e;

  localparam int SIM_DLY = 0;

  // Complex samples pack the real part in the upper half, imag in the lower half.
  function automatic int cplx_w(input int dw);
    return 2 * dw;
  endfunction

  function automatic int re_msb(input int dw);
    return 2 * dw - 1;
  endfunction

  function automatic int re_lsb(input int dw);
    return dw;
  endfunction

  function automatic int im_msb(input int dw);
    return dw - 1;
  endfunction

  function automatic int im_lsb(input int dw);
    return 0 * dw;
  endfunction

endpackage

// File: rtl/ftrans_neg_sat.sv
// DW-bit two's-complement negate with optional clamp of the most negative value.
// Build option: FTRANS_ROT_SAT_EN enables the clamp; otherwise the result wraps.
module ftrans_neg_sat #(
  parameter int DW = 16
) (
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          clamp
);

`ifdef FTRANS_ROT_SAT_EN
  localparam logic [DW-1:0] MIN_VAL = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0] MAX_VAL = {1'b0, {(DW-1){1'b1}}};

  always_comb begin
    clamp = (din == MIN_VAL);
    dout  = clamp ? MAX_VAL : (~din + 1'b1);
  end
`else
  assign dout  = ~din + 1'b1;
  assign clamp = 1'b0;
`endif

endmodule

// File: rtl/ftrans_rot.sv
// Trivial-twiddle (-j for FFT, +j for IFFT) rotation stage between BF-I and BF-II.
// Build option: FTRANS_ROT_SAT_EN selects saturating negation and a live osat flag.
module ftrans_rot
  import ftrans_rot_pkg::*;
#(
  parameter int TOTAL_STG = 7,
  parameter int FFT_STG   = 7,
  parameter int DW        = 16
) (
  input  logic                 iclk,
  input  logic                 irst,
  input  logic [2*DW-1:0]      idata,
  input  logic                 ien,
  input  logic                 isof,
  input  logic                 imode,
  output logic [2*DW-1:0]      odata,
  output logic [TOTAL_STG-1:0] oaddr,
  output logic                 oen,
  output logic                 osof,
  output logic                 oeof,
  output logic                 osat
);

  localparam int AW     = TOTAL_STG;
  localparam int CW     = cplx_w(DW);
  localparam int RE_MSB = re_msb(DW);
  localparam int RE_LSB = re_lsb(DW);
  localparam int IM_MSB = im_msb(DW);
  localparam int IM_LSB = im_lsb(DW);
  localparam int QHI    = FFT_STG - 1;
  localparam int QLO    = FFT_STG - 2;
  localparam int RE     = 1;
  localparam int IM     = 0;

  logic [AW-1:0]        cnt;
  mode_e                mode_reg;
  logic [AW-1:0]        idx;

  logic                 s1_valid;
  logic                 s1_sof;
  logic                 s1_eof;
  logic                 s1_rot;
  mode_e                s1_mode;
  logic [AW-1:0]        s1_idx;
  logic [1:0][DW-1:0]   s1_comp;

  logic [1:0][DW-1:0]   neg_comp;
  logic [1:0]           neg_clamp;
  logic [DW-1:0]        rot_re;
  logic [DW-1:0]        rot_im;
  logic                 rot_clamp;

  // An accepted isof restarts the frame at index 0 regardless of cnt.
  assign idx = isof ? '0 : cnt;

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      cnt      <= '0;
      mode_reg <= MODE_FFT;
      s1_valid <= 1'b0;
      s1_sof   <= 1'b0;
      s1_eof   <= 1'b0;
      s1_rot   <= 1'b0;
      s1_mode  <= MODE_FFT;
      s1_idx   <= '0;
      s1_comp  <= '0;
    end else begin
      s1_valid <= ien;
      if (ien) begin
        cnt     <= idx + 1'b1;
        s1_idx  <= idx;
        s1_sof  <= isof;
        s1_eof  <= &idx;
        s1_rot  <= &idx[QHI:QLO];
        s1_comp <= {idata[RE_MSB:RE_LSB], idata[IM_MSB:IM_LSB]};
        if (isof) begin
          mode_reg <= mode_e'(imode);
          s1_mode  <= mode_e'(imode);
        end else begin
          s1_mode  <= mode_reg;
        end
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_neg
    ftrans_neg_sat #(.DW(DW)) u_neg (
      .din   (s1_comp[gi]),
      .dout  (neg_comp[gi]),
      .clamp (neg_clamp[gi])
    );
  end

  always_comb begin
    rot_re    = s1_comp[RE];
    rot_im    = s1_comp[IM];
    rot_clamp = 1'b0;
    if (s1_rot) begin
      if (s1_mode == MODE_FFT) begin
        rot_re    = s1_comp[IM];
        rot_im    = neg_comp[RE];
        rot_clamp = neg_clamp[RE];
      end else begin
        rot_re    = neg_comp[IM];
        rot_im    = s1_comp[RE];
        rot_clamp = neg_clamp[IM];
      end
    end
  end

  // Data and address hold through bubbles; only the strobes drop.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      odata <= '0;
      oaddr <= '0;
      oen   <= 1'b0;
      osof  <= 1'b0;
      oeof  <= 1'b0;
    end else begin
      oen  <= s1_valid;
      osof <= s1_valid & s1_sof;
      oeof <= s1_valid & s1_eof;
      if (s1_valid) begin
        odata <= CW'({rot_re, rot_im});
        oaddr <= s1_idx;
      end
    end
  end

`ifdef FTRANS_ROT_SAT_EN
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      osat <= 1'b0;
    end else if (s1_valid) begin
      osat <= s1_sof ? rot_clamp : (osat | rot_clamp);
    end
  end
`else
  logic unused_clamp;
  assign unused_clamp = rot_clamp;
  assign osat         = 1'b0;
`endif

endmodule

// File: tb/tb_ftrans_rot.sv
// Self-checking bench for ftrans_rot: directed vector table, hand sequences for
// wrap / back-to-back / reset, and random traffic against a behavioural model.
module tb_ftrans_rot;

  localparam int TS = 7;
  localparam int DW = 16;
  localparam int FL = 128;
`ifdef FTRANS_ROT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [2*DW-1:0] idata;
  logic          ien, isof, imode;
  logic [2*DW-1:0] odata7, odata4;
  logic [TS-1:0] oaddr7, oaddr4;
  logic          oen7, osof7, oeof7, osat7;
  logic          oen4, osof4, oeof4, osat4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ftrans_rot #(.TOTAL_STG(TS), .FFT_STG(7), .DW(DW)) dut7 (
    .iclk(clk), .irst(rst), .idata(idata), .ien(ien), .isof(isof), .imode(imode),
    .odata(odata7), .oaddr(oaddr7), .oen(oen7), .osof(osof7), .oeof(oeof7), .osat(osat7)
  );

  ftrans_rot #(.TOTAL_STG(TS), .FFT_STG(4), .DW(DW)) dut4 (
    .iclk(clk), .irst(rst), .idata(idata), .ien(ien), .isof(isof), .imode(imode),
    .odata(odata4), .oaddr(oaddr4), .oen(oen4), .osof(osof4), .oeof(oeof4), .osat(osat4)
  );

  // ---------------- behavioural reference model ----------------
  typedef struct {
    bit valid;
    int addr;
    bit sof;
    bit eof;
    int re7, im7, re4, im4;
    bit cl7, cl4;
  } rec_t;

  int   m_cnt;
  bit   m_mode;
  rec_t st1;
  int   e_re[2];
  int   e_im[2];
  bit   e_sat[2];
  int   e_addr;
  bit   e_oen, e_osof, e_oeof;
  int   addr_log[$];

  function automatic rec_t empty_rec();
    rec_t r;
    r.valid = 0; r.addr = 0; r.sof = 0; r.eof = 0;
    r.re7 = 0; r.im7 = 0; r.re4 = 0; r.im4 = 0; r.cl7 = 0; r.cl4 = 0;
    return r;
  endfunction

  function automatic void neg_model(input int x, output int y, output bit c);
    if (x == -32768) begin
      c = SAT;
      y = SAT ? 32767 : -32768;
    end else begin
      c = 1'b0;
      y = -x;
    end
  endfunction

  // Multiply by -j (FFT) or +j (IFFT) when the quadrant of this stage is 3.
  function automatic void rot_model(input int idx, input int fs, input bit md, input int re,
                                    input int im, output int ore, output int oim, output bit cl);
    ore = re; oim = im; cl = 1'b0;
    if (((idx >> (fs - 2)) % 4) == 3) begin
      if (!md) begin
        ore = im;
        neg_model(re, oim, cl);
      end else begin
        neg_model(im, ore, cl);
        oim = re;
      end
    end
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_mode = 0; st1 = empty_rec();
    for (int d = 0; d < 2; d++) begin
      e_re[d] = 0; e_im[d] = 0; e_sat[d] = 0;
    end
    e_addr = 0; e_oen = 0; e_osof = 0; e_oeof = 0;
  endtask

  task automatic apply_out(input rec_t o);
    e_oen = o.valid; e_osof = o.valid & o.sof; e_oeof = o.valid & o.eof;
    if (o.valid) begin
      e_addr = o.addr;
      e_re[0] = o.re7; e_im[0] = o.im7; e_re[1] = o.re4; e_im[1] = o.im4;
      e_sat[0] = o.sof ? o.cl7 : (e_sat[0] | o.cl7);
      e_sat[1] = o.sof ? o.cl4 : (e_sat[1] | o.cl4);
    end
  endtask

  task automatic chk(input string name, input int d, input logic [2*DW-1:0] od,
                     input logic [TS-1:0] oa, input logic oe, input logic os,
                     input logic oef, input logic osa);
    logic [2*DW-1:0] xd;
    logic [TS-1:0]   xa;
    xd = {16'(e_re[d]), 16'(e_im[d])};
    xa = TS'(e_addr);
    checks++;
    if (od !== xd || oa !== xa || oe !== e_oen || os !== e_osof || oef !== e_oeof || osa !== e_sat[d]) begin
      failures++;
      $display("FAIL %s t=%0t actual odata=%h oaddr=%0d oen=%b osof=%b oeof=%b osat=%b required odata=%h oaddr=%0d oen=%b osof=%b oeof=%b osat=%b",
               name, $time, od, oa, oe, os, oef, osa, xd, xa, e_oen, e_osof, e_oeof, e_sat[d]);
    end
  endtask

  task automatic check_outputs();
    chk("cyc7", 0, odata7, oaddr7, oen7, osof7, oeof7, osat7);
    chk("cyc4", 1, odata4, oaddr4, oen4, osof4, oeof4, osat4);
  endtask

  // One clock: drive at negedge, advance model, compare at the following negedge.
  task automatic cycle(input bit en, input bit sof, input bit md, input int re, input int im);
    rec_t r;
    int   idx;
    bit   em;
    ien = en; isof = sof; imode = md; idata = {16'(re), 16'(im)};
    r = empty_rec();
    if (en) begin
      idx = sof ? 0 : m_cnt;
      em  = sof ? md : m_mode;
      if (sof) m_mode = md;
      m_cnt = (idx + 1) % FL;
      r.valid = 1; r.addr = idx; r.sof = sof; r.eof = (idx == FL - 1);
      rot_model(idx, 7, em, re, im, r.re7, r.im7, r.cl7);
      rot_model(idx, 4, em, re, im, r.re4, r.im4, r.cl4);
    end
    @(posedge clk);
    apply_out(st1);
    st1 = r;
    @(negedge clk);
    if (oen7) addr_log.push_back(int'(oaddr7));
    check_outputs();
  endtask

  task automatic frame(input bit md, input int n, input int re, input int im);
    for (int k = 0; k < n; k++) cycle(1'b1, k == 0, (k == 0) ? md : ~md, re, im);
  endtask

  task automatic expect_held(input string name, input int re7, input int im7,
                             input int re4, input int im4, input int addr,
                             input bit s7, input bit s4);
    logic [4*DW+2*TS+3:0] act, req;
    act = {odata7, odata4, oaddr7, oaddr4, oen7, oen4, osat7, osat4};
    req = {16'(re7), 16'(im7), 16'(re4), 16'(im4), TS'(addr), TS'(addr), 1'b0, 1'b0, s7, s4};
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit md;
    int idx;
    int re, im;
    int x7_re, x7_im, x4_re, x4_im;
    bit xsat;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int mn;
    mn = SAT ? 32767 : -32768;
    //            md idx  re      im      7re    7im    4re     4im
    tbl[0] = '{1'b0,   0, 100,    -50,    100,   -50,   100,    -50,    1'b0};
    tbl[1] = '{1'b0,  95, 100,    -50,    100,   -50,   -50,    -100,   1'b0};
    tbl[2] = '{1'b0,  96, 100,    -50,    -50,   -100,  100,    -50,    1'b0};
    tbl[3] = '{1'b0, 127, 100,    -50,    -50,   -100,  -50,    -100,   1'b0};
    tbl[4] = '{1'b1,  96, 100,    -50,    50,    100,   100,    -50,    1'b0};
    tbl[5] = '{1'b1,  50, 100,    -50,    100,   -50,   100,    -50,    1'b0};
    tbl[6] = '{1'b0,  12, 100,    -50,    100,   -50,   -50,    -100,   1'b0};
    tbl[7] = '{1'b0,  16, 100,    -50,    100,   -50,   100,    -50,    1'b0};
    tbl[8] = '{1'b1, 100, 5,      -32768, mn,    5,     5,      -32768, SAT};
    tbl[9] = '{1'b0, 110, -32768, 7,      7,     mn,    7,      mn,     SAT};

    rst = 1'b1; ien = 0; isof = 0; imode = 0; idata = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_outputs();
    rst = 1'b0;

    for (int v = 0; v < 10; v++) begin
      frame(tbl[v].md, tbl[v].idx + 1, tbl[v].re, tbl[v].im);
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      $display("vec %0d mode=%0d idx=%0d odata7=%h odata4=%h osat7=%b osat4=%b",
               v, tbl[v].md, tbl[v].idx, odata7, odata4, osat7, osat4);
      expect_held($sformatf("vec%0d", v), tbl[v].x7_re, tbl[v].x7_im,
                  tbl[v].x4_re, tbl[v].x4_im, tbl[v].idx, tbl[v].xsat, tbl[v].xsat);
    end

    // Saturation flag must persist into the next frame until its own osof.
    frame(1'b1, 101, 5, -32768);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 2);
    cycle(0, 0, 0, 0, 0);
    checks++;
    if (osat7 !== SAT) begin
      failures++;
      $display("FAIL sat_hold actual=%b required=%b", osat7, SAT);
    end
    $display("sat_hold osat7=%b", osat7);

    // Wrap: 130 samples with a single isof give addresses ... 127, 0, 1.
    addr_log.delete();
    frame(1'b0, 130, 100, -50);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    checks++;
    if (addr_log.size() != 130 || addr_log[127] != 127 || addr_log[128] != 0 || addr_log[129] != 1) begin
      failures++;
      $display("FAIL wrap actual n=%0d last=%0d,%0d,%0d required n=130 last=127,0,1", addr_log.size(),
               addr_log[addr_log.size()-3], addr_log[addr_log.size()-2], addr_log[addr_log.size()-1]);
    end
    $display("wrap n=%0d", addr_log.size());

    // Back-to-back frames FFT then IFFT, no gap between last and isof.
    frame(1'b0, FL, 100, -50);
    frame(1'b1, 97, 100, -50);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    $display("b2b odata7=%h", odata7);
    expect_held("b2b", 50, 100, 100, -50, 96, 1'b0, 1'b0);

    // Random traffic with gaps, mid-frame isof and occasional extreme values.
    for (int k = 0; k < 3000; k++) begin
      int re, im;
      re = $urandom_range(19) == 0 ? -32768 : int'($signed(16'($urandom)));
      im = $urandom_range(19) == 0 ? -32768 : int'($signed(16'($urandom)));
      cycle($urandom_range(4) != 0, $urandom_range(49) == 0, 1'($urandom), re, im);
    end
    $display("random done checks=%0d", checks);

    // Asynchronous reset at index 50 with samples in flight.
    frame(1'b1, 51, 100, -50);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({odata7, oaddr7, oen7, osof7, oeof7, osat7, odata4, oaddr4, oen4} !== '0) begin
      failures++;
      $display("FAIL async_rst actual odata7=%h oaddr7=%0d oen7=%b required all zero", odata7, oaddr7, oen7);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    check_outputs();
    cycle(1, 0, 1, 100, -50);
    cycle(0, 0, 0, 0, 0);
    frame(1'b0, 100, 100, -50);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    $display("post_rst oaddr7=%0d odata7=%h", oaddr7, odata7);
    expect_held("post_rst", -50, -100, 100, -50, 99, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
